// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic REQ_ACC  = 1'b0;
    localparam logic REQ_UART = 1'b1;

    // Control half of a requester bundle; address/data widths live in the arbiter.
    typedef struct packed {
        logic req;
        logic we;
    } req_ctrl_t;

    function automatic arb_state_t own_state(input logic id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one single-port synchronous memory
// between the accelerator (requester 0) and the UART controller (requester 1).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_dw,
    input  logic [DATA_WIDTH-1:0] mem_dr
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef struct packed {
        req_ctrl_t             ctrl;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_bundle_t;

    req_bundle_t rq [2];

    assign rq[0] = {r0_req, r0_we, r0_addr, r0_wdata};
    assign rq[1] = {r1_req, r1_we, r1_addr, r1_wdata};

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tag_valid_q, tag_valid_d;
    logic             tag_id_q, tag_id_d;

    logic gnt_any;
    logic sel;
    logic owner;

    always_comb begin
        gnt_any = 1'b0;
        sel     = REQ_ACC;
        owner   = (state_q == OWN1);
        case (state_q)
            IDLE: begin
                if (r0_req && r1_req) begin
                    gnt_any = 1'b1;
                    sel     = ~last_q;
                end else if (r0_req || r1_req) begin
                    gnt_any = 1'b1;
                    sel     = r1_req;
                end
            end
            OWN0, OWN1: begin
                if (rq[owner].ctrl.req) begin
                    gnt_any = 1'b1;
                    // Hand over only once the owner has used its burst and the other waits.
                    sel = (rq[~owner].ctrl.req && cnt_q >= BURST_MAX) ? ~owner : owner;
                end else if (rq[~owner].ctrl.req) begin
                    gnt_any = 1'b1;
                    sel     = ~owner;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        tag_valid_d = gnt_any & ~rq[sel].ctrl.we;
        tag_id_d    = sel;
        if (!gnt_any) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == own_state(sel)) begin
            if (cnt_q != BURST_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            state_d = own_state(sel);
            cnt_d   = CNT_W'(1);
            last_d  = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            tag_valid_q <= 1'b0;
            tag_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
        end
    end

    always_comb begin
        r0_gnt    = ~reset & gnt_any & (sel == REQ_ACC);
        r1_gnt    = ~reset & gnt_any & (sel == REQ_UART);
        mem_en    = ~reset & gnt_any;
        mem_we    = ~reset & gnt_any & rq[sel].ctrl.we;
        mem_addr  = rq[sel].addr;
        mem_dw    = rq[sel].wdata;
        r0_rvalid = ~reset & tag_valid_q & (tag_id_q == REQ_ACC);
        r1_rvalid = ~reset & tag_valid_q & (tag_id_q == REQ_UART);
        r0_rdata  = mem_dr;
        r1_rdata  = mem_dr;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_BURST=4) with a behavioural memory.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [15:0] r0_addr, r1_addr, mem_addr;
    logic [31:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, mem_dw, mem_dr;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, mem_en, mem_we;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dw(mem_dw),
        .mem_dr(mem_dr)
    );

    logic [31:0] mem [0:65535];
    bit          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            mem[16'h0010] <= 32'hDEADBEEF;
            mem[16'h0020] <= 32'hA5A50020;
            mem[16'h0030] <= 32'h5A5A0030;
            mem[16'h0060] <= 32'h60606060;
            mem[16'h0070] <= 32'h70707070;
            mem_init      <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_dw;
            else        mem_dr <= mem[mem_addr];
        end
    end

    typedef struct {
        bit          rst;
        bit          q0, w0;
        logic [15:0] a0;
        logic [31:0] d0;
        bit          q1, w1;
        logic [15:0] a1;
        logic [31:0] d1;
        bit          eg0, eg1, ewe;
        logic [15:0] eaddr;
        bit          ev0, ev1;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit q0, bit w0, logic [15:0] a0, logic [31:0] d0,
                                bit q1, bit w1, logic [15:0] a1, logic [31:0] d1,
                                bit eg0, bit eg1, bit ewe, logic [15:0] eaddr,
                                bit ev0, bit ev1, logic [31:0] erd);
        vec_t v;
        v.rst = rst; v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.eaddr = eaddr;
        v.ev0 = ev0; v.ev1 = ev1; v.erd = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit q0, input bit w0, input logic [15:0] a0,
                         input logic [31:0] d0, input bit q1, input bit w1,
                         input logic [15:0] a1, input logic [31:0] d1);
        @(negedge clk);
        reset = rst;
        r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
        #1;
    endtask

    task automatic check_gnt(input string tag, input bit eg0, input bit eg1);
        check({tag, " r0_gnt"}, 32'(r0_gnt), 32'(eg0));
        check({tag, " r1_gnt"}, 32'(r1_gnt), 32'(eg1));
        check({tag, " mem_en"}, 32'(mem_en), 32'(eg0 | eg1));
    endtask

    initial begin
        reset = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;

        // Reset forces outputs low even with requests present.
        vecs.push_back(mk(1, 1,0,16'h10,0, 1,0,16'h20,0, 0,0,0,0, 0,0,0));
        vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
        // Single reader.
        vecs.push_back(mk(0, 0,0,0,0, 1,0,16'h0010,0, 0,1,0,16'h0010, 0,0,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,32'hDEADBEEF));
        // First conflict after reset.
        vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
        vecs.push_back(mk(0, 1,0,16'h20,0, 1,0,16'h30,0, 1,0,0,16'h20, 0,0,0));
        vecs.push_back(mk(0, 0,0,0,0, 1,0,16'h30,0, 0,1,0,16'h30, 1,0,32'hA5A50020));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,32'h5A5A0030));
        // Burst limit 4 under continuous contention: 0000 1111 0000 1111.
        for (int i = 0; i < 16; i++) begin
            bit g0;
            g0 = ((i / 4) % 2) == 0;
            vecs.push_back(mk(0, 1,1,16'h40,32'h40400000 + i, 1,1,16'h50,32'h50500000 + i,
                              g0,!g0,1, g0 ? 16'h40 : 16'h50, 0,0,0));
        end
        // Cross-port write then read.
        vecs.push_back(mk(0, 0,0,0,0, 1,1,16'h0100,32'h12345678, 0,1,1,16'h0100, 0,0,0));
        vecs.push_back(mk(0, 1,0,16'h0100,0, 0,0,0,0, 1,0,0,16'h0100, 0,0,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,32'h12345678));
        // Reset mid-read drops the pending rvalid; fresh conflict goes to r0.
        vecs.push_back(mk(0, 1,0,16'h20,0, 0,0,0,0, 1,0,0,16'h20, 0,0,0));
        vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
        vecs.push_back(mk(0, 1,0,16'h60,0, 1,0,16'h70,0, 1,0,0,16'h60, 0,0,0));
        vecs.push_back(mk(0, 0,0,0,0, 1,0,16'h70,0, 0,1,0,16'h70, 1,0,32'h60606060));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,32'h70707070));
        // Idle gaps between single requests.
        vecs.push_back(mk(0, 1,1,16'h80,32'hCAFE0080, 0,0,0,0, 1,0,1,16'h80, 0,0,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0,0,0, 1,1,16'h90,32'hBEEF0090, 0,1,1,16'h90, 0,0,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0));

        foreach (vecs[i]) begin
            vec_t  v;
            string t;
            v = vecs[i];
            t = $sformatf("v%0d", i);
            drive(v.rst, v.q0, v.w0, v.a0, v.d0, v.q1, v.w1, v.a1, v.d1);
            check_gnt(t, v.eg0, v.eg1);
            check({t, " mem_we"}, 32'(mem_we), 32'(v.ewe));
            check({t, " r0_rvalid"}, 32'(r0_rvalid), 32'(v.ev0));
            check({t, " r1_rvalid"}, 32'(r1_rvalid), 32'(v.ev1));
            if (v.eg0 || v.eg1) check({t, " mem_addr"}, 32'(mem_addr), 32'(v.eaddr));
            if (v.ev0) check({t, " r0_rdata"}, r0_rdata, v.erd);
            if (v.ev1) check({t, " r1_rdata"}, r1_rdata, v.erd);
        end

        // Uncontended run saturates the burst counter; a newcomer wins immediately.
        for (int k = 0; k < 6; k++) begin
            drive(0, 1,1,16'h00A0 + 16'(k),32'hA0 + k, 0,0,0,0);
            check_gnt($sformatf("solo%0d", k), 1, 0);
        end
        drive(0, 1,1,16'h00A6,32'hA6, 1,1,16'h00B0,32'hB0);
        check("sat burst_cnt", 32'(dut.cnt_q), 32'd4);
        check("sat state", 32'(dut.state_q), 32'(OWN0));
        check_gnt("handover", 0, 1);
        drive(0, 1,1,16'h00A6,32'hA6, 0,0,0,0);
        check_gnt("return", 1, 0);
        drive(0, 0,0,0,0, 0,0,0,0);
        check_gnt("gap", 0, 0);
        drive(0, 0,0,0,0, 0,0,0,0);
        check("gap state", 32'(dut.state_q), 32'(IDLE));
        check("gap burst_cnt", 32'(dut.cnt_q), 32'd0);

        // Read back data written by each requester's write path.
        drive(0, 0,0,0,0, 1,0,16'h0080,0);
        check_gnt("rb80", 0, 1);
        drive(0, 1,0,16'h0050,0, 0,0,0,0);
        check_gnt("rb50", 1, 0);
        check("rb80 r1_rvalid", 32'(r1_rvalid), 32'd1);
        check("rb80 r1_rdata", r1_rdata, 32'hCAFE0080);
        drive(0, 0,0,0,0, 0,0,0,0);
        check("rb50 r0_rvalid", 32'(r0_rvalid), 32'd1);
        check("rb50 r0_rdata", r0_rdata, 32'h5050000F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous single-port 32-bit memory port between two requesters: requester 0 is the accelerator and requester 1 is the UART controller.
- It sits between the requesters and one port of memory3. This frees the second memory port, or allows a single-port memory.
- Arbitration is combinational and zero-cycle against registered state, so one access is issued per cycle.
- Ownership is round-robin with a bounded burst. This stops one requester from starving the other.

Parameters:
- ADDR_WIDTH, 16, memory word address width.
- DATA_WIDTH, 32, memory data width.
- MAX_BURST, 16, max consecutive grants to one owner while the other requester is waiting (>=1).

Ports:
- clk  in  1  system clock (divided clock domain).
- reset  in  1  synchronous, active-high.
- r0_req  in  1  requester 0 access request; held until r0_gnt.
- r0_we  in  1  requester 0 write enable (1 = write, 0 = read).
- r0_addr  in  ADDR_WIDTH  requester 0 address.
- r0_wdata  in  DATA_WIDTH  requester 0 write data.
- r0_gnt  out  1  access issued to memory this cycle.
- r0_rvalid  out  1  read data valid for requester 0.
- r0_rdata  out  DATA_WIDTH  read data for requester 0.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same definitions, for requester 1.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_dw  out  DATA_WIDTH  memory write data.
- mem_dr  in  DATA_WIDTH  memory read data; valid 1 cycle after an enabled read.

Behaviour:
- One clock: clk. Reset is synchronous and active-high.
- Registered state: state in {IDLE, OWN0, OWN1}, last_served (1 bit), burst_cnt (range 0..MAX_BURST, saturating), rd_tag (valid, id).
- Reset values:
  - state=IDLE, last_served=1 (so requester 0 wins the first conflict), burst_cnt=0, rd_tag.valid=0.
  - While reset=1, all outputs are forced to 0: r0_gnt, r1_gnt, mem_en, mem_we, r0_rvalid, r1_rvalid.
- Grant selection (combinational each cycle), where sel is the requester granted:
  - IDLE:
    - Exactly one req: grant it.
    - Both req: grant !last_served.
    - No req: no grant.
  - OWNx with rx_req=1:
    - Other requester idle, or burst_cnt<MAX_BURST: grant x.
    - Otherwise: grant the other requester.
  - OWNx with rx_req=0:
    - Other requester requesting: grant it.
    - Otherwise: no grant.
- Next state:
  - Grant to the same owner: burst_cnt++ (saturating).
  - Grant to a new owner: state=OWNnew, burst_cnt=1, last_served=new.
  - No grant: state=IDLE, burst_cnt=0.
- Memory drive:
  - mem_en = any gnt.
  - mem_we, mem_addr and mem_dw are muxed from the selected requester.
  - With no grant: mem_we=0, and addr/dw hold the requester-0 values (don't care).
- Read return:
  - On a granted read, rd_tag <= {1, sel}.
  - Next cycle, rx_rvalid=1 for the tagged id only.
  - r0_rdata = r1_rdata = mem_dr, unregistered. rvalid qualifies the data.
  - Writes produce no rvalid.
- Latency:
  - Grant: 0 cycles after req, when selected.
  - Read data: 1 cycle after grant.
  - Throughput: 1 access per cycle, with no bubble on ownership switch.
- Requesters must hold req/we/addr/wdata stable until gnt. Behaviour under violation is undefined.
- Simultaneous events:
  - Only one gnt is ever 1 in a cycle.
  - Requester 0 and requester 1 rvalid are never both 1.
- Reset mid-operation: any pending read tag is discarded, no rvalid follows, and state returns to IDLE.
- MAX_BURST=1 gives strict alternation under contention.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t.
  - typedef struct for the requester bundle (req, we, addr, wdata).
  - Constant REQ_ACC=0, REQ_UART=1.
- No sub-module needed. The burst counter is inline.
- Top-level integration:
  - acc gets a stall wrapper so its en is used as r0_req.
  - The controller drives r1.

Test Plan:
- Single reader, after reset: r1 read at 0x0010, with memory holding 0xDEADBEEF there → r1_gnt=1 in the same cycle, mem_addr=0x0010, mem_we=0; next cycle r1_rvalid=1, r1_rdata=0xDEADBEEF; r0_rvalid stays 0.
- First conflict, after reset: r0 and r1 both request in the same cycle → r0_gnt first; r1_gnt the following cycle, once r0 drops req.
- Burst limit, MAX_BURST=4: r0 and r1 both hold req continuously for 16 cycles → grant pattern 0000 1111 0000 1111; mem_en=1 every cycle.
- Cross-port write/read: r1 writes 0x12345678 @0x0100, then r0 reads 0x0100 → r0_rvalid=1 with 0x12345678 two cycles after the write grant; no rvalid is generated for the write.
- Reset mid-read: r0 read granted, then reset=1 the next cycle → r0_rvalid stays 0; after reset is released, a fresh conflict grants r0 first.
- Idle gaps: alternating single requests r0, idle, r1, idle → each gnt appears in the same cycle as its req; state returns to IDLE and burst_cnt=0 in the idle cycles.
